// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   seg_t       : 7-bit segment vector, bit 6 = a ... bit 0 = g, active-low
//   SEG_BLANK   : all segments dark
//   SEG_TAB     : hex nibble -> segment pattern table (index 0 at LSB end)
//   seg_of()    : table lookup helper
package sseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Packed so that SEG_TAB[v] is the pattern for nibble v.
  localparam logic [15:0][6:0] SEG_TAB = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // c
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  function automatic seg_t seg_of(input logic [3:0] v);
    return SEG_TAB[v];
  endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
//   nib : 4-bit hex value
//   seg : segments a..g (MSB = a), active-low
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = seg_of(nib);

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment display driver with leading-zero blanking.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : strobe capturing data / dp / digit_en
//   data       : one hex nibble per digit, digit i at [4i+3:4i]
//   dp         : decimal point per digit, 1 = lit
//   digit_en   : digit enable, 1 = enabled
//   lzb        : leading-zero blanking enable (live, not captured)
//   C          : segments a..g, active-low, registered
//   dp_n       : decimal point, active-low, registered
//   AN         : anodes, active-low, at most one low, registered
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzb,
  output logic [6:0]              C,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   AN
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]                cnt;
  logic [IW-1:0]                idx;
  logic                         tc;
  logic [NUM_DIGITS-1:0][3:0]   data_q;
  logic [NUM_DIGITS-1:0]        dp_q;
  logic [NUM_DIGITS-1:0]        en_q;
  logic [NUM_DIGITS-1:0][6:0]   seg_all;
  logic [NUM_DIGITS-1:0]        zero_or_off;
  logic [NUM_DIGITS-1:0]        lz;
  logic                         acc;
  logic                         blank;

  // Holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      dp_q   <= '0;
      en_q   <= '0;
    end else if (load) begin
      data_q <= data;
      dp_q   <= dp;
      en_q   <= digit_en;
    end
  end

  // Refresh counter and digit index
  assign tc = (cnt == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tc ? '0 : cnt + CW'(1);
      if (tc) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end
  end

  // Per-digit decode
  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      sseg_hex_decode u_dec (
        .nib (data_q[g]),
        .seg (seg_all[g])
      );
      assign zero_or_off[g] = (data_q[g] == 4'h0) | ~en_q[g];
    end
  endgenerate

  // lz[i] = this digit and every higher one are zero or disabled. A disabled
  // nonzero digit also sets it, but that digit is blanked regardless.
  always_comb begin
    acc = 1'b1;
    lz  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc   = acc & zero_or_off[i];
      lz[i] = lzb & acc;
    end
  end

  assign blank = ~en_q[idx] | (lz[idx] & (idx != '0));

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      C    <= SEG_BLANK;
      dp_n <= 1'b1;
      AN   <= '1;
    end else if (blank) begin
      C    <= SEG_BLANK;
      dp_n <= 1'b1;
      AN   <= '1;
    end else begin
      C    <= seg_all[idx];
      dp_n <= ~dp_q[idx];
      AN   <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule
